// File: rtl/duplex_buffer_register.sv
// duplex_buffer_register
//   Two-channel (A/B) buffer register. Each channel OR-merges data from its
//   transfer register and from the sense amps of its memory modules. Even
//   modules feed A and odd modules feed B. A channel can also be read out
//   serially, LSB first. A registered duplex comparator flags A/B mismatch.
//
//   Optional feature: define BRDX_PARITY_CHK_EN to build the per-channel
//   odd-parity checker. It drives a sticky PERR. Without the macro, PERR is
//   tied to 0.
//
// Parameters
//   WIDTH  bits per channel register (WIDTH-1 data bits, parity in the MSB)
//   NMOD   number of memory modules (even)
//
// Ports
//   V1      in   clock, rising edge
//   RST     in   synchronous active-high reset
//   CBRN    in   [1:0] active-low clear, [0]=A [1]=B
//   SBRX    in   [1:0] load-from-transfer strobe
//   TRA/TRB in   [WIDTH-2:0] transfer-register data
//   PAR     in   [1:0] transfer parity bit per channel
//   SA      in   [NMOD*WIDTH-1:0] sense-amp data, module m at SA[m*WIDTH +: WIDTH]
//   MSEL    in   [NMOD-1:0] per-module sense strobe
//   SGO     in   [1:0] serial readout start
//   CMPEN   in   duplex compare enable
//   BRA/BRB out  [WIDTH-1:0] register contents
//   SER     out  [1:0] serial bit, 0 when idle
//   BUSY    out  [1:0] channel is shifting
//   PERR    out  [1:0] sticky parity error
//   MISCMP  out  registered duplex miscompare
module duplex_buffer_register #(
  parameter int WIDTH = 14,
  parameter int NMOD  = 8
) (
  input  logic                    V1,
  input  logic                    RST,
  input  logic [1:0]              CBRN,
  input  logic [1:0]              SBRX,
  input  logic [WIDTH-2:0]        TRA,
  input  logic [WIDTH-2:0]        TRB,
  input  logic [1:0]              PAR,
  input  logic [NMOD*WIDTH-1:0]   SA,
  input  logic [NMOD-1:0]         MSEL,
  input  logic [1:0]              SGO,
  input  logic                    CMPEN,
  output logic [WIDTH-1:0]        BRA,
  output logic [WIDTH-1:0]        BRB,
  output logic [1:0]              SER,
  output logic [1:0]              BUSY,
  output logic [1:0]              PERR,
  output logic                    MISCMP
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam int         CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0][WIDTH-2:0] tr;
  logic [1:0][WIDTH-1:0] sense_or;
  logic [1:0]            sense_hit;
  logic [1:0][WIDTH-1:0] br_all;

  assign tr[0] = TRA;
  assign tr[1] = TRB;

  // Module m belongs to channel m%2; strobes of the other channel's modules
  // never reach this channel's merge term.
  always_comb begin
    sense_or  = '0;
    sense_hit = '0;
    for (int m = 0; m < NMOD; m++) begin
      if (MSEL[m]) begin
        sense_or[m % 2]  = sense_or[m % 2] | SA[m*WIDTH +: WIDTH];
        sense_hit[m % 2] = 1'b1;
      end
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] br;
    logic             idle;
    logic             load;
    logic             load_any;
    logic [WIDTH-1:0] br_next;

    assign idle     = (state == ST_IDLE);
    assign load     = SBRX[c] | sense_hit[c];
    // A clear counts as a load term for the purpose of dropping SGO.
    assign load_any = load | ~CBRN[c];
    assign br_next  = (CBRN[c] ? br : '0)
                    | (SBRX[c] ? {PAR[c], tr[c]} : '0)
                    | sense_or[c];

    always_ff @(posedge V1) begin
      if (RST) begin
        state <= ST_IDLE;
        cnt   <= '0;
        br    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            br <= br_next;
            if (SGO[c] && !load_any) begin
              state <= ST_SHIFT;
              cnt   <= '0;
            end
          end
          default: begin
            br <= br >> 1;
            if (cnt == CNT_LAST) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end

    assign br_all[c] = br;
    assign BUSY[c]   = (state == ST_SHIFT);
    assign SER[c]    = (state == ST_SHIFT) & br[0];

`ifdef BRDX_PARITY_CHK_EN
    logic chk_p1;
    logic perr;

    function automatic logic parity_bad(input logic [WIDTH-1:0] v);
      return ~(^v);
    endfunction

    // Check stage: chk_p1 marks the cycle after a load, when br holds the
    // merged value.
    always_ff @(posedge V1) begin
      if (RST) begin
        chk_p1 <= 1'b0;
        perr   <= 1'b0;
      end else begin
        chk_p1 <= idle & load;
        if (chk_p1 && parity_bad(br))
          perr <= 1'b1;
        else if (idle && !CBRN[c])
          perr <= 1'b0;
      end
    end

    assign PERR[c] = perr;
`else
    assign PERR[c] = 1'b0;
`endif
  end

  assign BRA = br_all[0];
  assign BRB = br_all[1];

  always_ff @(posedge V1) begin
    if (RST) begin
      MISCMP <= 1'b0;
    end else if (CMPEN && (BUSY == 2'b00)) begin
      MISCMP <= (br_all[0] != br_all[1]);
    end
  end

endmodule

// File: tb/tb_duplex_buffer_register.sv
// tb_duplex_buffer_register
//   Directed bench for duplex_buffer_register (WIDTH=14, NMOD=8). Stimulus
//   queues expected register values tagged with the cycle they must appear.
//   It also queues the expected serial bit stream. A negedge monitor pops and
//   compares these independently of the stimulus thread.
module tb_duplex_buffer_register;
  localparam int WIDTH = 14;
  localparam int NMOD  = 8;

  logic                  V1;
  logic                  RST;
  logic [1:0]            CBRN;
  logic [1:0]            SBRX;
  logic [WIDTH-2:0]      TRA;
  logic [WIDTH-2:0]      TRB;
  logic [1:0]            PAR;
  logic [NMOD*WIDTH-1:0] SA;
  logic [NMOD-1:0]       MSEL;
  logic [1:0]            SGO;
  logic                  CMPEN;
  logic [WIDTH-1:0]      BRA;
  logic [WIDTH-1:0]      BRB;
  logic [1:0]            SER;
  logic [1:0]            BUSY;
  logic [1:0]            PERR;
  logic                  MISCMP;

  duplex_buffer_register #(.WIDTH(WIDTH), .NMOD(NMOD)) dut (
    .V1(V1), .RST(RST), .CBRN(CBRN), .SBRX(SBRX), .TRA(TRA), .TRB(TRB),
    .PAR(PAR), .SA(SA), .MSEL(MSEL), .SGO(SGO), .CMPEN(CMPEN),
    .BRA(BRA), .BRB(BRB), .SER(SER), .BUSY(BUSY), .PERR(PERR), .MISCMP(MISCMP)
  );

  initial V1 = 1'b0;
  always #5 V1 = ~V1;

  // sel: 0 BRA, 1 BRB, 2 BUSY, 3 SER, 4 PERR[1], 5 MISCMP, 6 PERR
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sbq[$];
  logic ser_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge V1) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return 32'(BRA);
      1: return 32'(BRB);
      2: return 32'(BUSY);
      3: return 32'(SER);
      4: return 32'(PERR[1]);
      5: return 32'(MISCMP);
      default: return 32'(PERR);
    endcase
  endfunction

  always @(negedge V1) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      chk_t e;
      e = sbq.pop_front();
      total++;
      if (e.cyc != cyc || actual(e.sel) !== e.exp) begin
        bad++;
        $display("FAIL %s: got %0h want %0h (cycle %0d)", e.name, actual(e.sel), e.exp, cyc);
      end
    end
    if (BUSY[0]) begin
      total++;
      if (ser_q.size() == 0) begin
        bad++;
        $display("FAIL ser_extra: BUSY[0]=1 with no serial bit expected (cycle %0d)", cyc);
      end else begin
        logic b;
        b = ser_q.pop_front();
        if (SER[0] !== b) begin
          bad++;
          $display("FAIL ser_bit: got %0b want %0b (cycle %0d)", SER[0], b, cyc);
        end
      end
    end else if (SER[0] !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL ser_idle: got %0b want 0 (cycle %0d)", SER[0], cyc);
    end
  end

  task automatic tick();
    @(posedge V1);
    #1;
  endtask

  task automatic expect_v(input int sel, input logic [31:0] v, input string n);
    chk_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.exp  = v;
    e.name = n;
    sbq.push_back(e);
  endtask

  task automatic set_sa(input int m, input logic [WIDTH-1:0] v);
    SA[m*WIDTH +: WIDTH] = v;
  endtask

  task automatic push_ser(input logic [WIDTH-1:0] v, input int n);
    for (int i = 0; i < n; i++) ser_q.push_back(v[i]);
  endtask

  task automatic check_ser_drained(input string n);
    total++;
    if (ser_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d serial bits left, want 0", n, ser_q.size());
      ser_q.delete();
    end
  endtask

  logic perr_exp;

  initial begin
`ifdef BRDX_PARITY_CHK_EN
    perr_exp = 1'b1;
`else
    perr_exp = 1'b0;
`endif
    RST = 1'b1; CBRN = 2'b11; SBRX = '0; TRA = '0; TRB = '0; PAR = '0;
    SA = '0; MSEL = '0; SGO = '0; CMPEN = 1'b0;

    // Reset state
    tick(); tick();
    expect_v(0, 0, "rst_bra"); expect_v(1, 0, "rst_brb");
    expect_v(2, 0, "rst_busy"); expect_v(3, 0, "rst_ser");
    expect_v(6, 0, "rst_perr"); expect_v(5, 0, "rst_miscmp");
    RST = 1'b0;
    set_sa(4, 14'h3fff);  // unselected junk, must never leak in

    // Transfer load, then sense OR-merge
    SBRX = 2'b01; TRA = 13'h0005; PAR = 2'b01;
    tick(); SBRX = '0; PAR = '0;
    expect_v(0, 32'h2005, "load_tr");
    set_sa(2, 14'h0100); MSEL = 8'h04;
    tick(); MSEL = '0;
    expect_v(0, 32'h2105, "sense_merge");
    set_sa(3, 14'h2104); MSEL = 8'h08;
    tick(); MSEL = '0;
    expect_v(0, 32'h2105, "other_strobe_a");
    expect_v(1, 32'h2104, "msel3_sets_b");

    // Duplex compare
    CMPEN = 1'b1;
    tick();
    expect_v(5, 1, "miscmp_set");
    set_sa(3, 14'h0001); MSEL = 8'h08;
    tick(); MSEL = '0;
    expect_v(1, 32'h2105, "brb_equal");
    expect_v(5, 1, "miscmp_lag");
    tick();
    expect_v(5, 0, "miscmp_clr");
    CMPEN = 1'b0;

    // Serial readout of A; B loads meanwhile, A ignores its strobes
    push_ser(14'h2105, WIDTH);
    SGO = 2'b01;
    tick(); SGO = '0;
    expect_v(2, 32'h1, "busy_start");
    for (int k = 1; k < WIDTH; k++) begin
      if (k == 2) begin
        SBRX = 2'b01; TRA = 13'h1fff; PAR = 2'b01; CBRN = 2'b10;
        set_sa(1, 14'h0040); MSEL = 8'h02; SGO = 2'b01;
      end
      tick();
      SBRX = '0; PAR = '0; CBRN = 2'b11; MSEL = '0; SGO = '0;
      if (k == 2) expect_v(1, 32'h2145, "b_loads_while_a_shifts");
      if (k == WIDTH - 1) expect_v(2, 32'h1, "busy_last");
    end
    tick();
    expect_v(2, 0, "busy_end");
    expect_v(0, 0, "shift_zero");
    check_ser_drained("ser_count");

    // SGO coincident with load is dropped
    SGO = 2'b01; SBRX = 2'b01; TRA = 13'h0010; PAR = 2'b01;
    tick(); SGO = '0; SBRX = '0; PAR = '0;
    expect_v(0, 32'h2010, "sgo_load_applied");
    expect_v(2, 0, "sgo_dropped");
    tick();
    expect_v(2, 0, "sgo_dropped2");

    // Clear and load together keeps only the loaded value
    CBRN = 2'b10; SBRX = 2'b01; TRA = 13'h0003; PAR = 2'b01;
    tick(); CBRN = 2'b11; SBRX = '0; PAR = '0;
    expect_v(0, 32'h2003, "clr_load");

    // Parity on channel B
    CBRN = 2'b01;
    tick(); CBRN = 2'b11;
    expect_v(1, 0, "clr_b");
    expect_v(4, 0, "perr_b_clear");
    SBRX = 2'b10; TRB = 13'h0003; PAR = 2'b00;
    tick(); SBRX = '0;
    expect_v(1, 32'h0003, "load_b_even");
    tick();
    expect_v(4, 32'(perr_exp), "perr_set");
    tick();
    expect_v(4, 32'(perr_exp), "perr_hold");
    CBRN = 2'b01;
    tick(); CBRN = 2'b11;
    expect_v(4, 0, "perr_clr");

    // Reset during the 5th shift cycle
    push_ser(14'h2003, 5);
    SGO = 2'b01;
    tick(); SGO = '0;
    repeat (4) tick();
    RST = 1'b1;
    tick(); RST = 1'b0;
    expect_v(2, 0, "rst_mid_busy"); expect_v(3, 0, "rst_mid_ser");
    expect_v(0, 0, "rst_mid_bra");  expect_v(6, 0, "rst_mid_perr");
    tick(); tick();
    check_ser_drained("ser_rst_count");
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d checks pending, want 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/duplex_buffer_register.md
DUPLEX_BUFFER_REGISTER -- requirements
Module: duplex_buffer_register

Interface
REQ-001 SHALL have parameter WIDTH, default 14, meaning bits per channel register (WIDTH-1 data bits plus 1 parity bit in the MSB).
REQ-002 SHALL have parameter NMOD, default 8, meaning memory modules; even-numbered modules feed channel A, odd-numbered modules feed channel B; NMOD is even.
REQ-003 SHALL have port V1  in  1  clock; the only clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port CBRN  in  2  per-channel clear, active-low, [0]=A, [1]=B.
REQ-006 SHALL have port SBRX  in  2  per-channel load-from-transfer strobe.
REQ-007 SHALL have port TRA, TRB  in  WIDTH-1 each  transfer-register data.
REQ-008 SHALL have port PAR  in  2  transfer parity bit per channel.
REQ-009 SHALL have port SA  in  NMOD*WIDTH  sense-amp data; module m occupies SA[m*WIDTH +: WIDTH].
REQ-010 SHALL have port MSEL  in  NMOD  per-module sense strobe.
REQ-011 SHALL have port SGO  in  2  per-channel serial-readout start.
REQ-012 SHALL have port CMPEN  in  1  duplex compare enable.
REQ-013 SHALL have ports BRA, BRB  out  WIDTH each  register contents.
REQ-014 SHALL have ports SER  out 2, serial bit per channel; BUSY  out 2, channel shifting.
REQ-015 SHALL have ports PERR  out 2, sticky parity error; MISCMP  out 1, duplex miscompare.

Function
REQ-016 Channel next value in IDLE SHALL be (CBRN ? BR : 0) | (SBRX ? {PAR,TR} : 0) | OR of SA slices of that channel's modules with MSEL set; loads OR-merge, they do not overwrite.
REQ-017 Clear and load in the same cycle SHALL yield only the loaded value(s).
REQ-018 Strobes of the other channel's modules SHALL have no effect on a channel.
REQ-019 Each channel SHALL have state machine IDLE -> SHIFT on SGO when no load term (SBRX, own MSEL, CBRN low) is active that cycle; SGO coincident with a load SHALL be dropped and the load applied.
REQ-020 In SHIFT, SER SHALL present BR[0] each cycle and BR shift right with zero fill; a counter runs WIDTH cycles, then returns to IDLE; BUSY=1 exactly WIDTH cycles starting the cycle after SGO.
REQ-021 In SHIFT, CBRN, SBRX, MSEL and SGO SHALL be ignored for that channel; after completion BR=0.
REQ-022 SER SHALL be 0 in IDLE.
REQ-023 MISCMP SHALL be registered: set the cycle after CMPEN=1, both BUSY=0 and BRA!=BRB; cleared the cycle after CMPEN=1, both idle and equal; held otherwise.
REQ-024 Channels SHALL operate independently; one may shift while the other loads.

Reset
REQ-025 RST SHALL override all inputs: BRA=BRB=0, SER=0, BUSY=0, PERR=0, MISCMP=0, both FSMs IDLE, counters 0, including mid-shift.

Configuration
REQ-026 With BRDX_PARITY_CHK_EN defined, the cycle after any load a channel SHALL check odd parity over all WIDTH bits and set PERR on even parity; PERR is sticky until CBRN low in IDLE or RST.
REQ-027 Without BRDX_PARITY_CHK_EN, PERR SHALL be constant 0 and no parity logic is built; all other behaviour is identical.

Verification
REQ-028 RST mid-shift (cycle 5 of 14) -> next cycle BUSY=0, SER=0, BRA=0, PERR=0.
REQ-029 SBRX[0]=1, TRA=13'h0005, PAR[0]=1, then MSEL[2]=1 with slice 14'h0100 -> BRA=14'h2105; MSEL[3] alone leaves BRA unchanged, sets BRB.
REQ-030 BRA=14'h2105, SGO[0]=1 -> BUSY[0]=1 for 14 cycles, SER[0] sequence 1,0,1,0,0,0,0,0,1,0,0,0,0,1, then BRA=0.
REQ-031 SGO[0] with SBRX[0] same cycle -> load applied, BUSY[0] stays 0.
REQ-032 BRDX_PARITY_CHK_EN defined: load BRB=14'h0003 -> PERR[1]=1 next cycle, held until CBRN[1]=0; undefined: PERR=0.
REQ-033 CMPEN=1, BRA=14'h2105, BRB=14'h2104 -> MISCMP=1 next cycle; after BRB set equal -> MISCMP=0.
